tcm: RTL and testbench

TCM -- requirements
Module: tcm

---
 rtl/tcm.sv | 110 +++++++++++
 tb/tb_tcm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm.sv
// Tightly coupled memory: byte-addressable little-endian store with
// one write port (byte/half/word) and two independent 16-byte read ports.
//
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   bus_tcm_fetch_*          fetch read port (addr, rd) -> tcm_bus_fetch_data
//   bus_tcm_stbuf_read_*     data read port (addr, size, rd) -> tcm_bus_stbuf_data
//   bus_tcm_stbuf_write_*    write port (addr, size) with bus_tcm_stbuf_data/wr
module tcm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_DATA_WIDTH = 128,
    parameter int REG_DATA_WIDTH = 32,
    parameter int SIZE_WIDTH     = 2,
    parameter int TCM_SIZE       = 16384
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     bus_tcm_fetch_addr,
    input  logic                      bus_tcm_fetch_rd,
    output logic [BUS_DATA_WIDTH-1:0] tcm_bus_fetch_data,
    input  logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr,
    input  logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size,
    input  logic                      bus_tcm_stbuf_rd,
    output logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data,
    input  logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
    input  logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
    input  logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data,
    input  logic                      bus_tcm_stbuf_wr
);

    localparam int IDX_W    = $clog2(TCM_SIZE);
    localparam int RD_BYTES = BUS_DATA_WIDTH / 8;

    logic [7:0] mem [TCM_SIZE];

    logic [IDX_W-1:0] fetch_base;
    logic [IDX_W-1:0] read_base;
    logic [IDX_W-1:0] write_base;

    logic [3:0]       lane_en;
    logic [IDX_W-1:0] lane_idx [4];

    logic [BUS_DATA_WIDTH-1:0] fetch_next;
    logic [BUS_DATA_WIDTH-1:0] read_next;

    // Read size has no effect on returned data; upper address bits are
    // dropped because addresses wrap modulo the memory size.
    logic unused_bits;
    assign unused_bits = ^{bus_tcm_stbuf_read_size, bus_tcm_fetch_addr,
                           bus_tcm_stbuf_read_addr, bus_tcm_stbuf_write_addr,
                           bus_tcm_stbuf_data};

    assign fetch_base = bus_tcm_fetch_addr[IDX_W-1:0];
    assign read_base  = bus_tcm_stbuf_read_addr[IDX_W-1:0];
    assign write_base = bus_tcm_stbuf_write_addr[IDX_W-1:0];

    // Byte lanes of the store word that land in memory this cycle.
    always_comb begin
        lane_en = 4'b0000;
        unique case (bus_tcm_stbuf_write_size)
            SIZE_WIDTH'(0): lane_en = 4'b0001;
            SIZE_WIDTH'(1): lane_en = 4'b0011;
            SIZE_WIDTH'(2): lane_en = 4'b1111;
            default:        lane_en = 4'b0000;
        endcase
        if (!rst || !bus_tcm_stbuf_wr) begin
            lane_en = 4'b0000;
        end
    end

    // Index arithmetic is IDX_W wide, so crossing the top wraps to 0.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_idx[k] = write_base + IDX_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
                mem[lane_idx[k]] <= bus_tcm_stbuf_data[8*k +: 8];
            end
        end
    end

    // Reads see memory before this edge's write lands.
    always_comb begin
        fetch_next = '0;
        read_next  = '0;
        for (int k = 0; k < RD_BYTES; k++) begin
            fetch_next[8*k +: 8] = mem[fetch_base + IDX_W'(k)];
            read_next[8*k +: 8]  = mem[read_base + IDX_W'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcm_bus_fetch_data <= '0;
            tcm_bus_stbuf_data <= '0;
        end else begin
            if (bus_tcm_fetch_rd) begin
                tcm_bus_fetch_data <= fetch_next;
            end
            if (bus_tcm_stbuf_rd) begin
                tcm_bus_stbuf_data <= read_next;
            end
        end
    end

endmodule

// File: tb/tb_tcm.sv
// Self-checking bench for tcm: byte-level reference model compared on
// every cycle, plus directed vectors with literal expectations.
module tb_tcm;

    localparam int AW = 32;
    localparam int BW = 128;
    localparam int RW = 32;
    localparam int SW = 2;
    localparam int S  = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] fetch_addr;
    logic          fetch_rd;
    logic [BW-1:0] fetch_data;
    logic [AW-1:0] read_addr;
    logic [SW-1:0] read_size;
    logic          read_rd;
    logic [BW-1:0] stbuf_data;
    logic [AW-1:0] write_addr;
    logic [SW-1:0] write_size;
    logic [RW-1:0] write_data;
    logic          write_wr;

    always #5 clk = ~clk;

    tcm #(
        .ADDR_WIDTH(AW), .BUS_DATA_WIDTH(BW), .REG_DATA_WIDTH(RW),
        .SIZE_WIDTH(SW), .TCM_SIZE(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_tcm_fetch_addr(fetch_addr),
        .bus_tcm_fetch_rd(fetch_rd),
        .tcm_bus_fetch_data(fetch_data),
        .bus_tcm_stbuf_read_addr(read_addr),
        .bus_tcm_stbuf_read_size(read_size),
        .bus_tcm_stbuf_rd(read_rd),
        .tcm_bus_stbuf_data(stbuf_data),
        .bus_tcm_stbuf_write_addr(write_addr),
        .bus_tcm_stbuf_write_size(write_size),
        .bus_tcm_stbuf_data(write_data),
        .bus_tcm_stbuf_wr(write_wr)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain byte array plus a written-flag per byte.
    logic [7:0]    mm [S];
    bit            mv [S];
    logic [BW-1:0] ef, es;
    logic [15:0]   mf, ms;
    bit            model_ok = 0;

    always @(posedge clk) begin
        int unsigned idx;
        int n;
        if (!rst) begin
            ef = '0;
            es = '0;
            mf = '1;
            ms = '1;
            model_ok = 1;
        end else begin
            if (fetch_rd) begin
                for (int k = 0; k < 16; k++) begin
                    idx = (fetch_addr + 32'(k)) % S;
                    ef[8*k +: 8] = mm[idx];
                    mf[k] = mv[idx];
                end
            end
            if (read_rd) begin
                for (int k = 0; k < 16; k++) begin
                    idx = (read_addr + 32'(k)) % S;
                    es[8*k +: 8] = mm[idx];
                    ms[k] = mv[idx];
                end
            end
            if (write_wr) begin
                n = (write_size == 2'd0) ? 1 : (write_size == 2'd1) ? 2 :
                    (write_size == 2'd2) ? 4 : 0;
                for (int k = 0; k < n; k++) begin
                    idx = (write_addr + 32'(k)) % S;
                    mm[idx] = write_data[8*k +: 8];
                    mv[idx] = 1;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [BW-1:0] got,
                       input logic [BW-1:0] exp, input logic [15:0] m);
        bit bad;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (m[k] && (got[8*k +: 8] !== exp[8*k +: 8])) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s got=%h exp=%h mask=%h", nm, got, exp, m);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (model_ok) begin
            cmp("fetch_model", fetch_data, ef, mf);
            cmp("stbuf_model", stbuf_data, es, ms);
        end
    end

    task automatic lit(input string nm, input logic [BW-1:0] got,
                       input logic [BW-1:0] exp, input int nbits);
        logic [BW-1:0] m;
        m = (nbits >= BW) ? '1 : ((BW'(1) << nbits) - BW'(1));
        checks++;
        if ((got & m) !== (exp & m)) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got & m, exp & m);
        end
    endtask

    task automatic step(input bit f_rd, input logic [AW-1:0] f_a,
                        input bit s_rd, input logic [AW-1:0] s_a,
                        input bit w, input logic [AW-1:0] w_a,
                        input logic [SW-1:0] w_s, input logic [RW-1:0] w_d);
        fetch_rd   = f_rd;
        fetch_addr = f_a;
        read_rd    = s_rd;
        read_addr  = s_a;
        read_size  = SW'($urandom_range(3));
        write_wr   = w;
        write_addr = w_a;
        write_size = w_s;
        write_data = w_d;
        @(posedge clk);
        #1;
        fetch_rd = 0;
        read_rd  = 0;
        write_wr = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [SW-1:0] s,
                      input logic [RW-1:0] d);
        step(0, '0, 0, '0, 1, a, s, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1, a, 1, a, 0, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] v0, v1, d;
        logic [AW-1:0] a;
        rst = 0;
        fetch_rd = 0; fetch_addr = '0;
        read_rd = 0; read_addr = '0; read_size = '0;
        write_wr = 0; write_addr = '0; write_size = '0; write_data = '0;
        step(1, '0, 1, '0, 0, '0, '0, '0);
        step(0, '0, 0, '0, 0, '0, '0, '0);
        lit("reset_fetch", fetch_data, '0, BW);
        lit("reset_stbuf", stbuf_data, '0, BW);
        rst = 1;

        wr(32'h0, 2'd0, 32'ha5a5a5a5);
        rd(32'h0);
        lit("byte_write", stbuf_data, 128'ha5, 8);

        wr(32'h0, 2'd2, 32'h12345678);
        wr(32'h4, 2'd2, 32'h90abcdef);
        step(1, 32'h0, 1, 32'h4, 0, '0, '0, '0);
        lit("word0_fetch", fetch_data, 128'h12345678, 32);
        lit("word4_stbuf", stbuf_data, 128'h90abcdef, 32);
        rd(32'h4);
        lit("word4_fetch", fetch_data, 128'h90abcdef, 32);
        rd(32'h3);
        lit("unal3_fetch", fetch_data, 128'habcdef12, 32);
        lit("unal3_stbuf", stbuf_data, 128'habcdef12, 32);

        wr(32'h8, 2'd1, 32'ha55a);
        wr(32'ha, 2'd0, 32'hcc);
        wr(32'hb, 2'd2, 32'ha5cbeeac);
        wr(32'hf, 2'd0, 32'hcb);
        wr(32'h10, 2'd2, 32'haabbccdd);
        rd(32'h0);
        lit("line0_fetch", fetch_data,
            128'hcba5cbee_accca55a_90abcdef_12345678, 128);
        lit("line0_stbuf", stbuf_data,
            128'hcba5cbee_accca55a_90abcdef_12345678, 128);
        rd(32'h5);
        lit("line5_stbuf", stbuf_data, 128'hcba5cbee_accca55a_90abcd, 88);
        rd(32'hc);
        lit("linec_fetch", fetch_data, 128'haabbccdd_cba5cbee, 64);

        step(1, 32'h0, 0, '0, 1, 32'h0, 2'd0, 32'h55);
        lit("rw_same_cycle", fetch_data, 128'h12345678, 32);
        rd(32'h0);
        lit("rw_after", stbuf_data, 128'h12345655, 32);

        wr(32'h20, 2'd2, 32'h11223344);
        wr(32'h20, 2'd3, 32'hffffffff);
        rd(32'h20);
        lit("size3_nop", stbuf_data, 128'h11223344, 32);

        wr(S - 2, 2'd2, 32'hdeadbeef);
        rd(S - 2);
        lit("wrap_fetch", fetch_data, 128'hdeadbeef, 32);
        lit("wrap_stbuf", stbuf_data, 128'hdeadbeef, 32);

        for (int i = 0; i < 4096; i++) wr(32'(4 * i), 2'd2, 32'(i + 65536));
        for (int i = 0; i < 4096; i++) begin
            rd(32'(4 * i));
            lit("seq_word", stbuf_data, BW'(32'(i + 65536)), 32);
            if (i < 4095) begin
                rd(32'(4 * i + 2));
                v0 = 32'(i + 65536);
                v1 = 32'(i + 65537);
                lit("seq_half", fetch_data, BW'((v0 >> 16) | (v1 << 16)), 32);
            end
        end

        for (int n = 0; n < 20000; n++) begin
            a = (n < 3) ? AW'(S - 1 - n) : AW'($urandom_range(S - 1));
            d = $urandom;
            wr(a, 2'd2, d);
            rd(a);
            lit("rand_fetch", fetch_data, BW'(d), 32);
            lit("rand_stbuf", stbuf_data, BW'(d), 32);
        end

        wr(32'h100, 2'd2, 32'hcafef00d);
        rd(32'h100);
        rst = 0;
        step(1, 32'h100, 1, 32'h100, 1, 32'h100, 2'd2, 32'h11111111);
        lit("midrst_fetch", fetch_data, '0, BW);
        lit("midrst_stbuf", stbuf_data, '0, BW);
        rst = 1;
        rd(32'h100);
        lit("retain_fetch", fetch_data, 128'hcafef00d, 32);
        lit("retain_stbuf", stbuf_data, 128'hcafef00d, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
